lzc_dichotomy_pipe: RTL



---
 rtl/lzc_pkg.sv | 19 +
 rtl/lzc_dichotomy_stage.sv | 94 +++++++++
 rtl/lzc_dichotomy_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// Shared types and helpers for the pipelined dichotomy leading-zero counter.
package lzc_pkg;

  localparam int LZC_DEF_WIDTH = 8;
  localparam int LZC_DEF_TAG_W = 4;

  function automatic int lzc_cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Result bundle at default widths; width-generic users declare the same
  // layout locally with lzc_cnt_w(WIDTH).
  typedef struct packed {
    logic [lzc_cnt_w(LZC_DEF_WIDTH)-1:0] cnt;
    logic                                zero;
    logic [LZC_DEF_TAG_W-1:0]            tag;
  } lzc_res_t;

endpackage

// File: rtl/lzc_dichotomy_stage.sv
// One halving step of the leading-zero counter with a valid/ready register slice.
// Optional normalising shift is present when LZC_NORM_EN is defined.
module lzc_dichotomy_stage
  import lzc_pkg::*;
#(
  parameter int WIN_W  = LZC_DEF_WIDTH,
  parameter int STAGE  = 0,
  parameter int CNT_W  = lzc_cnt_w(LZC_DEF_WIDTH),
`ifdef LZC_NORM_EN
  parameter int NORM_W = LZC_DEF_WIDTH,
`endif
  parameter int TAG_W  = LZC_DEF_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIN_W-1:0]   i_win,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic [TAG_W-1:0]   i_tag,
`ifdef LZC_NORM_EN
  input  logic [NORM_W-1:0]  i_norm,
  output logic [NORM_W-1:0]  o_norm,
`endif
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIN_W/2-1:0] o_win,
  output logic [CNT_W-1:0]   o_cnt,
  output logic [TAG_W-1:0]   o_tag
);

  localparam int HALF = WIN_W / 2;
  localparam logic [CNT_W-1:0] CNT_BIT = CNT_W'(1) << (CNT_W - 1 - STAGE);

  logic              w_upper_zero;
  logic              w_load;
  logic [HALF-1:0]   w_win_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              r_valid;
  logic [HALF-1:0]   r_win;
  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_tag;
`ifdef LZC_NORM_EN
  logic [NORM_W-1:0] w_norm_nx;
  logic [NORM_W-1:0] r_norm;
`endif

  assign w_upper_zero = ~|i_win[WIN_W-1:HALF];
  assign o_ready      = ~r_valid | i_ready;
  assign w_load       = i_valid & o_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_win_nx = i_win[WIN_W-1:HALF];
    w_cnt_nx = i_cnt;
`ifdef LZC_NORM_EN
    w_norm_nx = i_norm;
`endif
    if (w_upper_zero) begin
      w_win_nx = i_win[HALF-1:0];
      w_cnt_nx = i_cnt | CNT_BIT;
`ifdef LZC_NORM_EN
      w_norm_nx = i_norm << HALF;
`endif
    end
  end

  // NOTE: state is updated with non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else if (o_ready) r_valid <= i_valid;
  end

  // NOTE: payload has no reset; it is only ever observed qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_win <= w_win_nx;
      r_cnt <= w_cnt_nx;
      r_tag <= i_tag;
`ifdef LZC_NORM_EN
      r_norm <= w_norm_nx;
`endif
    end
  end

  assign o_valid = r_valid;
  assign o_win   = r_win;
  assign o_cnt   = r_cnt;
  assign o_tag   = r_tag;
`ifdef LZC_NORM_EN
  assign o_norm  = r_norm;
`endif

endmodule

// File: rtl/lzc_dichotomy_pipe.sv
// Streaming leading-zero counter: one count bit per registered stage, MSB first.
// Define LZC_NORM_EN to add the normalised-word output out_norm.
module lzc_dichotomy_pipe
  import lzc_pkg::*;
#(
  parameter  int WIDTH = LZC_DEF_WIDTH,
  parameter  int TAG_W = LZC_DEF_TAG_W,
  localparam int CNT_W = lzc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
`ifdef LZC_NORM_EN
  output logic [WIDTH-1:0] out_norm,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Windows of width WIDTH, WIDTH/2, ..., 1 packed end to end.
  localparam int BUS_W = 2 * WIDTH - 1;

  logic [BUS_W-1:0] w_win_bus;
  logic [CNT_W:0]   w_valid;
  logic [CNT_W:0]   w_ready;
  logic [CNT_W-1:0] w_cnt [CNT_W+1];
  logic [TAG_W-1:0] w_tag [CNT_W+1];
  res_t             w_res;
`ifdef LZC_NORM_EN
  logic [WIDTH-1:0] w_norm [CNT_W+1];

  assign w_norm[0] = in_data;
`endif

  assign w_win_bus[WIDTH-1:0] = in_data;
  assign w_valid[0]           = in_valid;
  assign w_ready[CNT_W]       = out_ready;
  assign w_cnt[0]             = '0;
  assign w_tag[0]             = in_tag;
  assign in_ready             = w_ready[0];

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    localparam int WIN_W = WIDTH >> k;
    localparam int OFF_I = 2 * WIDTH - 2 * WIN_W;
    localparam int OFF_O = 2 * WIDTH - WIN_W;

    lzc_dichotomy_stage #(
      .WIN_W  (WIN_W),
      .STAGE  (k),
      .CNT_W  (CNT_W),
`ifdef LZC_NORM_EN
      .NORM_W (WIDTH),
`endif
      .TAG_W  (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_win   (w_win_bus[OFF_I +: WIN_W]),
      .i_cnt   (w_cnt[k]),
      .i_tag   (w_tag[k]),
`ifdef LZC_NORM_EN
      .i_norm  (w_norm[k]),
      .o_norm  (w_norm[k+1]),
`endif
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1]),
      .o_win   (w_win_bus[OFF_O +: WIN_W/2]),
      .o_cnt   (w_cnt[k+1]),
      .o_tag   (w_tag[k+1])
    );
  end

  // Outputs read zero whenever no result is presented.
  always_comb begin
    w_res = '0;
    if (w_valid[CNT_W]) begin
      w_res.cnt  = w_cnt[CNT_W];
      w_res.zero = ~w_win_bus[BUS_W-1];
      w_res.tag  = w_tag[CNT_W];
    end
  end

  assign out_valid = w_valid[CNT_W];
  assign out_cnt   = w_res.cnt;
  assign out_zero  = w_res.zero;
  assign out_tag   = w_res.tag;
`ifdef LZC_NORM_EN
  assign out_norm  = w_valid[CNT_W] ? w_norm[CNT_W] : '0;
`endif

endmodule
